// File: rtl/v2f_mem_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, access sizes, response
// ids and the per-transaction record held between accept and response.
package v2f_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic ID_IF = 1'b0;
  localparam logic ID_D  = 1'b1;

  // Fields of the accepted request needed to shape the response.
  typedef struct packed {
    logic       id;
    logic [1:0] off;
    logic [1:0] size;
    logic       sgn;
  } req_t;

endpackage

// File: rtl/v2f_ram_arbiter_if.sv
// Bus bundle between requesters/RAM and the arbiter.
// slave  : the arbiter's view (serves requests, drives the RAM ports).
// master : the environment's view (requesters plus the RAM read data).
interface v2f_ram_arbiter_if #(
  parameter int ABITS = 2
);
  logic             IF_REQ_VALID;
  logic             IF_REQ_READY;
  logic [ABITS+1:0] IF_REQ_ADDR;
  logic             D_REQ_VALID;
  logic             D_REQ_READY;
  logic [ABITS+1:0] D_REQ_ADDR;
  logic             D_REQ_WE;
  logic [1:0]       D_REQ_SIZE;
  logic             D_REQ_SIGNED;
  logic [31:0]      D_REQ_WDATA;
  logic             RSP_VALID;
  logic             RSP_ID;
  logic [31:0]      RSP_DATA;
  logic             RSP_ERR;
  logic             INIT_DONE;
  logic             RAM_RD_EN;
  logic [ABITS-1:0] RAM_RD_ADDR;
  logic [31:0]      RAM_RD_DATA;
  logic             RAM_WR_EN;
  logic [ABITS-1:0] RAM_WR_ADDR;
  logic [31:0]      RAM_WR_DATA;
  logic [3:0]       RAM_BYTE_SELECT;
  logic             RAM_ARST;

  modport slave (
    input  IF_REQ_VALID, IF_REQ_ADDR,
    input  D_REQ_VALID, D_REQ_ADDR, D_REQ_WE, D_REQ_SIZE, D_REQ_SIGNED, D_REQ_WDATA,
    input  RAM_RD_DATA,
    output IF_REQ_READY, D_REQ_READY,
    output RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, INIT_DONE,
    output RAM_RD_EN, RAM_RD_ADDR, RAM_WR_EN, RAM_WR_ADDR, RAM_WR_DATA,
    output RAM_BYTE_SELECT, RAM_ARST
  );

  modport master (
    output IF_REQ_VALID, IF_REQ_ADDR,
    output D_REQ_VALID, D_REQ_ADDR, D_REQ_WE, D_REQ_SIZE, D_REQ_SIGNED, D_REQ_WDATA,
    output RAM_RD_DATA,
    input  IF_REQ_READY, D_REQ_READY,
    input  RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, INIT_DONE,
    input  RAM_RD_EN, RAM_RD_ADDR, RAM_WR_EN, RAM_WR_ADDR, RAM_WR_DATA,
    input  RAM_BYTE_SELECT, RAM_ARST
  );
endinterface

// File: rtl/v2f_mem_lane.sv
// Combinational byte-lane logic: store replication and byte selects,
// misalignment/illegal-size detection, and load shift/mask/extension.
module v2f_mem_lane import v2f_mem_pkg::*; (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_wr_data,
  output logic [3:0]  st_bsel,
  output logic        st_err,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sgn,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] ld_sh;

  // Store data replicated across every lane it could land in; alignment check.
  always_comb begin
    case (st_size)
      SZ_BYTE: st_wr_data = {4{st_wdata[7:0]}};
      SZ_HALF: st_wr_data = {2{st_wdata[15:0]}};
      SZ_WORD: st_wr_data = st_wdata;
      default: st_wr_data = '0;
    endcase
    st_err = (st_size == 2'd3) ||
             (st_size == SZ_HALF && st_off[0]) ||
             (st_size == SZ_WORD && st_off != 2'd0);
  end

  // Each byte lane decides independently whether the access covers it.
  for (genvar i = 0; i < 4; i++) begin : g_bsel
    localparam logic [1:0] LANE = 2'(i);
    assign st_bsel[i] = (st_size == SZ_WORD) ||
                        (st_size == SZ_HALF && LANE[1] == st_off[1]) ||
                        (st_size == SZ_BYTE && LANE == st_off);
  end

  // Right-align the addressed bytes, then zero- or sign-extend.
  always_comb begin
    ld_sh = ld_raw >> {ld_off, 3'b000};
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sgn & ld_sh[7]}}, ld_sh[7:0]};
      SZ_HALF: ld_data = {{16{ld_sgn & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/v2f_ram_arbiter.sv
// Arbiter/sequencer sharing one RAM read and one write port between the
// instruction-fetch and load/store requesters, one transaction at a time.
// Optional feature macro: V2F_ARB_ROUND_ROBIN_EN (round-robin grant);
// without it D has fixed priority over IF.
module v2f_ram_arbiter import v2f_mem_pkg::*; #(
  parameter int ABITS = 2
) (
  input logic              CLK,
  input logic              ARST_N,
  v2f_ram_arbiter_if.slave bus
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        arst_q, arst_d;
  logic        init_q, init_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic             gnt_dport;
  logic             acc, rd_go, wr_go;
  logic [ABITS+1:0] a_addr;
  logic [1:0]       a_size;
  logic             a_sgn, a_we;
  logic [31:0]      lane_wr_data, lane_ld_data;
  logic [3:0]       lane_bsel;
  logic             lane_err;

`ifdef V2F_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Last-served port; the other port wins a tie next time.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) last_q <= ID_D;
    else         last_q <= last_d;
  end

  // Grant selection with round-robin tie break.
  always_comb begin
    if (bus.D_REQ_VALID && bus.IF_REQ_VALID) gnt_dport = (last_q == ID_IF);
    else                                     gnt_dport = bus.D_REQ_VALID;
    last_d = acc ? gnt_dport : last_q;
  end
`else
  // Grant selection, D has fixed priority.
  always_comb begin
    gnt_dport = bus.D_REQ_VALID;
  end
`endif

  // Winning request fields; IF is always an unsigned word load.
  always_comb begin
    acc    = (state_q == ST_IDLE) && (bus.D_REQ_VALID || bus.IF_REQ_VALID);
    a_addr = gnt_dport ? bus.D_REQ_ADDR : bus.IF_REQ_ADDR;
    a_size = gnt_dport ? bus.D_REQ_SIZE : SZ_WORD;
    a_sgn  = gnt_dport & bus.D_REQ_SIGNED;
    a_we   = gnt_dport & bus.D_REQ_WE;
    rd_go  = acc && !lane_err && !a_we;
    wr_go  = acc && !lane_err && a_we;
  end

  v2f_mem_lane u_lane (
    .st_size    (a_size),
    .st_off     (a_addr[1:0]),
    .st_wdata   (bus.D_REQ_WDATA),
    .st_wr_data (lane_wr_data),
    .st_bsel    (lane_bsel),
    .st_err     (lane_err),
    .ld_size    (req_q.size),
    .ld_off     (req_q.off),
    .ld_sgn     (req_q.sgn),
    .ld_raw     (bus.RAM_RD_DATA),
    .ld_data    (lane_ld_data)
  );

  assign bus.D_REQ_READY     = acc && gnt_dport;
  assign bus.IF_REQ_READY    = acc && !gnt_dport;
  assign bus.RAM_RD_EN       = rd_go;
  assign bus.RAM_RD_ADDR     = rd_go ? a_addr[ABITS+1:2] : '0;
  assign bus.RAM_WR_EN       = wr_go;
  assign bus.RAM_WR_ADDR     = wr_go ? a_addr[ABITS+1:2] : '0;
  assign bus.RAM_WR_DATA     = wr_go ? lane_wr_data : '0;
  assign bus.RAM_BYTE_SELECT = wr_go ? lane_bsel : '0;
  assign bus.RAM_ARST        = arst_q;
  assign bus.INIT_DONE       = init_q;
  assign bus.RSP_VALID       = rsp_vld_q;
  assign bus.RSP_ID          = rsp_id_q;
  assign bus.RSP_DATA        = rsp_data_q;
  assign bus.RSP_ERR         = rsp_err_q;

  // Next state and registered response; response fields are 0 when idle.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    arst_d     = 1'b0;
    init_d     = init_q;
    rsp_vld_d  = 1'b0;
    rsp_id_d   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    case (state_q)
      // First edge after release raises the strobe, second leaves LOAD.
      ST_LOAD: begin
        if (!arst_q) arst_d = 1'b1;
        else begin
          state_d = ST_IDLE;
          init_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (acc) begin
          req_d = '{id: gnt_dport, off: a_addr[1:0], size: a_size, sgn: a_sgn};
          if (lane_err || a_we) begin
            state_d   = ST_RESP;
            rsp_vld_d = 1'b1;
            rsp_id_d  = gnt_dport;
            rsp_err_d = lane_err;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        state_d    = ST_RESP;
        rsp_vld_d  = 1'b1;
        rsp_id_d   = req_q.id;
        rsp_data_d = lane_ld_data;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_LOAD;
    endcase
  end

  // State and response registers; reset drops any in-flight transaction.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q    <= ST_LOAD;
      req_q      <= '0;
      arst_q     <= 1'b0;
      init_q     <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      arst_q     <= arst_d;
      init_q     <= init_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: doc/v2f_ram_arbiter.md
# v2f_ram_arbiter

Sequencer and arbiter in front of `v2f_programmable_ram`. It shares the RAM's single read port and single write port between an instruction-fetch requester (IF) and a load/store requester (D). It also generates byte selects and lane alignment for sub-word accesses. After reset it pulses the RAM's program-load strobe once, then reports `INIT_DONE`.

## Interface
Parameters:
- `ABITS`, default 2: RAM word-address width. Requester byte addresses are `ABITS+2` bits wide.

Ports:
- `CLK` in 1: single clock. The RAM `RD_CLK`/`WR_CLK` are tied to it externally.
- `ARST_N` in 1: reset, asynchronous, active-low.
- `IF_REQ_VALID` in 1: fetch request.
- `IF_REQ_READY` out 1: fetch request accepted this cycle.
- `IF_REQ_ADDR` in ABITS+2: fetch byte address. Always a word access.
- `D_REQ_VALID` in 1: data request.
- `D_REQ_READY` out 1: data request accepted this cycle.
- `D_REQ_ADDR` in ABITS+2: data byte address.
- `D_REQ_WE` in 1: 1 = store, 0 = load.
- `D_REQ_SIZE` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `D_REQ_SIGNED` in 1: sign-extend sub-word loads.
- `D_REQ_WDATA` in 32: store data, right-aligned.
- `RSP_VALID` out 1: one-cycle response pulse. There is no backpressure.
- `RSP_ID` out 1: 0 = IF, 1 = D.
- `RSP_DATA` out 32: load data, right-aligned and extended. 0 for stores and errors.
- `RSP_ERR` out 1: misaligned or illegal request.
- `INIT_DONE` out 1: program load finished. Stays high until the next reset.
- `RAM_RD_EN` out 1: RAM read enable.
- `RAM_RD_ADDR` out ABITS: RAM read word address.
- `RAM_RD_DATA` in 32: RAM read data (RAM read latency is 1 cycle).
- `RAM_WR_EN` out 1: RAM write enable.
- `RAM_WR_ADDR` out ABITS: RAM write word address.
- `RAM_WR_DATA` out 32: RAM write data.
- `RAM_BYTE_SELECT` out 4: RAM byte-lane write enables.
- `RAM_ARST` out 1: RAM program-load strobe.

## Operation
- States: LOAD, IDLE, WAIT, RESP.
- Reset (`ARST_N`=0):
  - State goes to LOAD.
  - Every output is 0.
  - Any pending transaction is dropped silently. No response is issued for it.
- LOAD:
  - Lasts exactly one cycle after reset release.
  - `RAM_ARST`=1 in that cycle.
  - Then go to IDLE and set `INIT_DONE`=1.
- IDLE:
  - `x_REQ_READY` = (state==IDLE) && `x_REQ_VALID` && (grant==x). At most one READY is high per cycle.
  - On accept, register id, address, size and signed.
  - Illegal or misaligned request: no RAM access; go to RESP with `RSP_ERR`=1. Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0. Size 3 is illegal.
  - Load/fetch: in the accept cycle drive `RAM_RD_EN`=1 and `RAM_RD_ADDR`=`addr[ABITS+1:2]`; go to WAIT.
  - Store: in the accept cycle drive `RAM_WR_EN`=1 and `RAM_WR_ADDR`=`addr[ABITS+1:2]`; go to RESP. Lane generation:
    - byte: `WR_DATA`={4{wdata[7:0]}}, `BYTE_SELECT`=1<<addr[1:0].
    - half: `WR_DATA`={2{wdata[15:0]}}, `BYTE_SELECT`=addr[1] ? 4'b1100 : 4'b0011.
    - word: `WR_DATA`=wdata, `BYTE_SELECT`=4'b1111.
- WAIT: capture `RAM_RD_DATA` >> (8*addr[1:0]), mask to the request size, sign- or zero-extend; go to RESP.
- RESP: `RSP_VALID`=1 for one cycle with the registered id/data/err; go to IDLE.
- Exactly one transaction is outstanding at a time. All RAM enables are 0 outside the IDLE accept cycle.

## Timing
- Request accepted in cycle N:
  - store or error: `RSP_VALID` in N+1.
  - load or fetch: `RSP_VALID` in N+2.
- The next accept is possible in N+2 (store/error) or N+3 (load).
- A store accepted in N is visible to a load accepted in N+2 or later.
- `REQ_READY` is combinational from `REQ_VALID` and state. `RSP_*` are registered.

## Configuration
- `V2F_ARB_ROUND_ROBIN_EN` defined:
  - A last-served register, reset to D, records the last granted port.
  - When both ports are valid, the port not served last wins.
- Not defined: fixed priority, D over IF. No last-served register exists.

## Structure
- Package `v2f_mem_pkg` holds:
  - state encoding (LOAD/IDLE/WAIT/RESP);
  - size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2);
  - response IDs (ID_IF=0, ID_D=1).
- Sub-module `v2f_mem_lane` is combinational and contains:
  - store replication and byte-select generation;
  - load shift, mask and sign-extension;
  - the misalignment check.

## Test plan
- Reset release → `RAM_ARST`=1 for exactly 1 cycle, `INIT_DONE`=1 from the next cycle, all other outputs 0 before it.
- D store byte `addr`=0x6, `wdata`=0xA5 → `RAM_WR_ADDR`=1, `WR_DATA`=0xA5A5A5A5, `BYTE_SELECT`=4'b0100; `RSP_VALID`/`ID`=1/`ERR`=0 one cycle later.
- RAM word 1 = 0x80F0_1234; D signed half load at 0x6 → `RSP_DATA`=0xFFFF80F0 at N+2; unsigned byte load at 0x5 → 0x00000012.
- D half at 0x3 and D size 3 → no RAM enables, `RSP_ERR`=1 at N+1; IF fetch at 0x2 → `RSP_ERR`=1, `RSP_ID`=0.
- IF and D both valid continuously: without the macro only D is granted; with `V2F_ARB_ROUND_ROBIN_EN` grants alternate IF, D, IF, D.
- `ARST_N` dropped during WAIT → no `RSP_VALID`; after release LOAD repeats and `INIT_DONE` deasserts then reasserts.
